// File: rtl/fpmul_rr_sched.sv
// Round-robin scheduler sharing one AXI-stream FP multiplier among NREQ requesters.
// Optional issue counter output issue_cnt is enabled by defining FPMUL_RR_SCHED_CNT_EN.
module fpmul_rr_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_vld,
  input  logic [NREQ*64-1:0]   req_a,
  input  logic [NREQ*64-1:0]   req_b,
  output logic [NREQ-1:0]      req_rdy,
  output logic                 mul_tvalid,
  output logic [63:0]          mul_a_tdata,
  output logic [63:0]          mul_b_tdata,
  input  logic                 mul_a_tready,
  input  logic                 mul_b_tready,
  input  logic                 mul_res_tvalid,
  input  logic [63:0]          mul_res_tdata,
  output logic                 mul_res_tready,
  output logic [NREQ-1:0]      res_vld,
  output logic [63:0]          res_data,
`ifdef FPMUL_RR_SCHED_CNT_EN
  output logic [31:0]          issue_cnt,
`endif
  output logic                 err_unexp
);

  localparam int unsigned TagW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  // Issue slot
  logic            slot_vld_q, slot_vld_d;
  logic [63:0]     slot_a_q, slot_a_d;
  logic [63:0]     slot_b_q, slot_b_d;
  logic [TagW-1:0] slot_tag_q, slot_tag_d;

  // Arbiter
  logic [TagW-1:0] rr_q, rr_d;
  logic [TagW-1:0] grant_idx;
  logic            grant_found;

  // Tag FIFO
  logic [TagW-1:0]  mem_q [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // Result stage
  logic [NREQ-1:0] res_vld_q, res_vld_d;
  logic [63:0]     res_data_q, res_data_d;
  logic            err_q, err_d;

  logic            slot_cons;
  logic            slot_load;
  logic            push;
  logic            pop;
  logic            fifo_empty;
  logic [TagW-1:0] pop_tag;
  logic [CntW:0]   outstanding;

  assign slot_cons   = slot_vld_q & mul_a_tready & mul_b_tready;
  assign outstanding = {1'b0, cnt_q} + {{CntW{1'b0}}, slot_vld_q};
  assign fifo_empty  = (cnt_q == '0);
  assign push        = slot_cons;
  // An empty FIFO with a same-cycle push forwards the pushed tag straight through.
  assign pop         = mul_res_tvalid & (~fifo_empty | push);
  assign pop_tag     = fifo_empty ? slot_tag_q : mem_q[rd_ptr_q];

  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (!grant_found && req_vld[idx]) begin
        grant_found = 1'b1;
        grant_idx   = TagW'(idx);
      end
    end
  end

  // Gating with rst_n keeps req_rdy low for the whole time reset is held.
  assign slot_load = rst_n & grant_found & (~slot_vld_q | slot_cons) &
                     (outstanding < (CntW + 1)'(DEPTH));

  always_comb begin
    req_rdy = '0;
    if (slot_load) begin
      req_rdy[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_a_d   = slot_a_q;
    slot_b_d   = slot_b_q;
    slot_tag_d = slot_tag_q;
    rr_d       = rr_q;
    if (slot_load) begin
      slot_vld_d = 1'b1;
      slot_a_d   = req_a[64*grant_idx +: 64];
      slot_b_d   = req_b[64*grant_idx +: 64];
      slot_tag_d = grant_idx;
      rr_d       = (grant_idx == TagW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if (slot_cons) begin
      slot_vld_d = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == AddrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == AddrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    res_vld_d  = '0;
    res_data_d = res_data_q;
    err_d      = err_q | (mul_res_tvalid & ~pop);
    if (pop) begin
      res_vld_d[pop_tag] = 1'b1;
      res_data_d         = mul_res_tdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld_q <= 1'b0;
      slot_a_q   <= '0;
      slot_b_q   <= '0;
      slot_tag_q <= '0;
      rr_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      res_vld_q  <= '0;
      res_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      slot_vld_q <= slot_vld_d;
      slot_a_q   <= slot_a_d;
      slot_b_q   <= slot_b_d;
      slot_tag_q <= slot_tag_d;
      rr_q       <= rr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      res_vld_q  <= res_vld_d;
      res_data_q <= res_data_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= slot_tag_q;
    end
  end

`ifdef FPMUL_RR_SCHED_CNT_EN
  logic [31:0] issue_cnt_q, issue_cnt_d;

  assign issue_cnt_d = slot_cons ? issue_cnt_q + 32'd1 : issue_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign issue_cnt = issue_cnt_q;
`endif

  assign mul_tvalid     = slot_vld_q;
  assign mul_a_tdata    = slot_a_q;
  assign mul_b_tdata    = slot_b_q;
  assign mul_res_tready = 1'b1;
  assign res_vld        = res_vld_q;
  assign res_data       = res_data_q;
  assign err_unexp      = err_q;

endmodule

// File: doc/fpmul_rr_sched.md
FPMUL_RR_SCHED -- requirements
Module: fpmul_rr_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one floating_point_0 multiplier instance.
REQ-002 SHALL have parameter DEPTH, default 16, max operations in flight, a power of two.
REQ-003 SHALL have port clk  in  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_vld  in  NREQ  per-requester operation valid.
REQ-006 SHALL have port req_a / req_b  in  NREQ*64 each  operand A/B, requester i at bits [64i+63:64i].
REQ-007 SHALL have port req_rdy  out  NREQ  one-hot accept; a request transfers when req_vld[i] & req_rdy[i].
REQ-008 SHALL have port mul_tvalid  out  1  drives s_axis_a_tvalid and s_axis_b_tvalid.
REQ-009 SHALL have port mul_a_tdata / mul_b_tdata  out  64 each  multiplier operands.
REQ-010 SHALL have port mul_a_tready / mul_b_tready  in  1 each  multiplier input readies.
REQ-011 SHALL have port mul_res_tvalid / mul_res_tdata  in  1 / 64  multiplier result.
REQ-012 SHALL have port mul_res_tready  out  1  tied 1.
REQ-013 SHALL have port res_vld  out  NREQ  one-hot result strobe to the owning requester.
REQ-014 SHALL have port res_data  out  64  result value, valid with res_vld.
REQ-015 SHALL have port err_unexp  out  1  sticky: result arrived with no op outstanding.

Function
REQ-016 Issue slot: one register holding {a, b, tag}; mul_tvalid = slot valid; slot consumed when mul_tvalid & mul_a_tready & mul_b_tready.
REQ-017 Slot contents SHALL stay stable while mul_tvalid=1 and not consumed.
REQ-018 Slot loads when (slot empty or consumed this cycle) and any req_vld and outstanding < DEPTH; outstanding = tag-FIFO count + slot valid.
REQ-019 Arbitration: round-robin from pointer rr; grant = first i at or after rr (mod NREQ) with req_vld[i]; req_rdy = grant one-hot only when slot loads, else 0.
REQ-020 On grant to g, rr <= (g+1) mod NREQ; unchanged when nothing is granted.
REQ-021 Latency: request accepted at cycle N -> mul_tvalid=1 at N+1.
REQ-022 Tag FIFO, DEPTH entries, in-order: push granted tag on slot consumption; pop on mul_res_tvalid.
REQ-023 Result: mul_res_tvalid at cycle M -> res_vld[popped tag]=1 and res_data=mul_res_tdata at M+1, one cycle only.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and be correct at count 0 and DEPTH.
REQ-025 With outstanding=DEPTH, req_rdy SHALL be all 0; FIFO never overflows.
REQ-026 mul_res_tvalid with FIFO empty: drop result, no res_vld, set err_unexp until reset.
REQ-027 Same-cycle slot load and result return SHALL both complete.

Reset
REQ-028 rst_n=0 SHALL immediately clear: slot valid, mul_tvalid, req_rdy, res_vld, err_unexp, FIFO count/pointers, rr=0; data registers 0.
REQ-029 Reset mid-operation SHALL discard all in-flight tags; results arriving after release and before any new issue set err_unexp.

Configuration
REQ-030 Macro FPMUL_RR_SCHED_CNT_EN: when defined, adds output issue_cnt (32 bits), reset 0, +1 per slot consumption, wraps 0xFFFFFFFF->0.
REQ-031 Without FPMUL_RR_SCHED_CNT_EN, issue_cnt port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-032 req_vld=4'b1111 held, treadys=1 -> grants 0,1,2,3,0 on consecutive cycles.
REQ-033 req_vld[2] only, a=0x4000000000000000 (2.0), b=0x4008000000000000 (3.0), model latency 8 -> res_vld=4'b0100, res_data=0x4018000000000000 (6.0), one cycle.
REQ-034 Hold mul_a_tready=0 five cycles with slot full -> slot data stable, req_rdy=0, no FIFO push.
REQ-035 Results held back, all requesters valid -> exactly 16 accepts then req_rdy=0; first result re-enables one accept next cycle.
REQ-036 Inject mul_res_tvalid with nothing outstanding -> no res_vld, err_unexp=1 until rst_n=0.
REQ-037 Assert rst_n=0 with 3 ops in flight -> outputs clear same cycle; late results set err_unexp.
